// File: rtl/axi_rd_resp_router_pkg.sv
// Shared types and constants for the AXI read-response router and its output stage.
package axi_rd_resp_router_pkg;

  // AXI read response codes
  typedef enum logic [1:0] {
    RRESP_OKAY   = 2'b00,
    RRESP_EXOKAY = 2'b01,
    RRESP_SLVERR = 2'b10,
    RRESP_DECERR = 2'b11
  } rresp_e;

  // Router FSM encodings
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // Sticky error flag layout
  localparam int ERR_W     = 3;
  localparam int ERR_RRESP = 0;  // response other than OKAY on an accepted beat
  localparam int ERR_ID    = 1;  // popped ID was zero or had several bits set
  localparam int ERR_BEAT  = 2;  // rlast position disagrees with the burst length

endpackage

// File: rtl/axi_rd_out_reg.sv
// One-entry registered valid/ready stage carrying {sel, last, data}.
// The one-hot sel picks which consumer sees valid; data and last are shared.
// Generic enough to serve the write-response path as well.
module axi_rd_out_reg #(
  parameter int SEL_W  = 2,
  parameter int DATA_W = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic              i_last,
  input  logic [DATA_W-1:0] i_data,
  input  logic [SEL_W-1:0]  i_ready,
  output logic              o_in_ready,
  output logic [SEL_W-1:0]  o_valid,
  output logic              o_last,
  output logic [DATA_W-1:0] o_data
);

  logic              r_full;
  logic [SEL_W-1:0]  r_sel;
  logic              r_last;
  logic [DATA_W-1:0] r_data;
  logic              w_drain;

  // The held entry leaves when the consumer it targets is ready.
  assign w_drain    = r_full & (|(i_ready & r_sel));
  assign o_in_ready = ~r_full | w_drain;
  assign o_valid    = r_sel & {SEL_W{r_full}};
  assign o_last     = r_last;
  assign o_data     = r_data;

  // Capture a new entry or release the current one; contents hold while stalled.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the data register is reset too, because out_data must read zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 1'b0;
      r_sel  <= '0;
      r_last <= 1'b0;
      r_data <= '0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_sel  <= i_sel;
      r_last <= i_last;
      r_data <= i_data;
    end else if (w_drain) begin
      r_full <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_rd_resp_router.sv
// Routes each AXI R-channel burst to the decompressor whose one-hot ID sits at the
// head of the ID queue, popping one ID per burst with no bubble between bursts.
// Optional feature: define BEAT_CHECK_EN to add the burst-length checker behind err[2].
module axi_rd_resp_router
  import axi_rd_resp_router_pkg::*;
#(
  parameter int NUM_DECOMPRESSOR = 2,
  parameter int DATA_WIDTH       = 512,
  parameter int BURST_LEN        = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_DECOMPRESSOR-1:0] id_select,
  input  logic                        id_empty,
  output logic                        id_rd_en,
  input  logic                        m_rvalid,
  output logic                        m_rready,
  input  logic [DATA_WIDTH-1:0]       m_rdata,
  input  logic                        m_rlast,
  input  logic [1:0]                  m_rresp,
  output logic [NUM_DECOMPRESSOR-1:0] out_valid,
  input  logic [NUM_DECOMPRESSOR-1:0] out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_last,
  output logic [ERR_W-1:0]            err,
  input  logic                        err_clr
);

  localparam int N = NUM_DECOMPRESSOR;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [N-1:0]     r_sel_q;
  logic [ERR_W-1:0] r_err;
  logic [ERR_W-1:0] w_err_set;
  logic             w_sel_ok;
  logic             w_id_ok;
  logic             w_stage_ready;
  logic             w_accept;
  logic             w_load;
  logic             w_beat_err;

  function automatic logic is_onehot(input logic [N-1:0] v);
    return (v != '0) && ((v & (v - N'(1))) == '0);
  endfunction

  // A burst with a bad ID is swallowed: beats are accepted but never loaded.
  assign w_sel_ok = is_onehot(r_sel_q);
  assign w_id_ok  = is_onehot(id_select);
  assign w_accept = m_rvalid & m_rready;
  assign w_load   = w_accept & w_sel_ok;

  axi_rd_out_reg #(
    .SEL_W  (N),
    .DATA_W (DATA_WIDTH)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_sel      (r_sel_q),
    .i_last     (m_rlast),
    .i_data     (m_rdata),
    .i_ready    (out_ready),
    .o_in_ready (w_stage_ready),
    .o_valid    (out_valid),
    .o_last     (out_last),
    .o_data     (out_data)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, R-channel ready and ID pop; m_rready never looks at m_rvalid.
  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    m_rready    = 1'b0;
    id_rd_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!id_empty) begin
          id_rd_en    = 1'b1;
          w_state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        m_rready = w_sel_ok ? w_stage_ready : 1'b1;
        if (m_rvalid && m_rready && m_rlast) begin
          if (id_empty) w_state_nxt = ST_IDLE;
          else          id_rd_en    = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Latch the head ID whenever it is popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_sel_q <= '0;
    else if (id_rd_en) r_sel_q <= id_select;
  end

`ifdef BEAT_CHECK_EN
  localparam int                BEAT_W    = $clog2(BURST_LEN) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  logic [BEAT_W-1:0] r_beat_cnt;

  // Beat index within the current burst, restarted on every pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_beat_cnt <= '0;
    else if (id_rd_en) r_beat_cnt <= '0;
    else if (w_accept) r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
  end

  assign w_beat_err = w_accept && (m_rlast != (r_beat_cnt == LAST_BEAT));
`else
  assign w_beat_err = 1'b0;
`endif

  // BURST_LEN only shapes the beat checker, but an unusable value is rejected in every build.
  if (BURST_LEN < 2) begin : g_burst_len_check
    $error("axi_rd_resp_router: BURST_LEN must be at least 2");
  end

  // Error set terms for this cycle.
  always_comb begin
    w_err_set            = '0;
    w_err_set[ERR_RRESP] = w_accept && (m_rresp != RRESP_OKAY);
    w_err_set[ERR_ID]    = id_rd_en && !w_id_ok;
    w_err_set[ERR_BEAT]  = w_beat_err;
  end

  // Sticky flags; a set in the same cycle as err_clr wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= '0;
    else     r_err <= (r_err & ~{ERR_W{err_clr}}) | w_err_set;
  end

  assign err = r_err;

endmodule
